path_replayer: RTL and testbench

- Downstream consumer of the 2-bit direction stack used by the maze solver.
- After a solve, it drains the stack destructively through its pop interface and buffers the popped entries locally. Because the stack returns the last move first, it then replays the moves in forward order, first move first.
- Each replayed move is presented on a valid/ready output together with the grid coordinate reached, feeding the path display/checker stage.

---
 rtl/path_replayer_pkg.sv | 48 ++++
 rtl/path_replayer_buffer.sv | 26 ++
 rtl/path_replayer.sv | 160 ++++++++++++++++
 tb/tb_path_replayer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_replayer_pkg.sv
// Shared definitions for the maze path replay slice: direction codes,
// replayer FSM encoding and the single-step coordinate update used by
// both the replayer and the downstream path checker.
package path_replayer_pkg;

  // Direction codes as stored on the solver's direction stack.
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  // Coordinates are carried at this width inside step(); callers keep the
  // low COORD_W bits, which gives modulo-2^COORD_W wrap for free.
  localparam int STEP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRAIN = 2'b01,
    ST_EMIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  typedef struct packed {
    logic [STEP_W-1:0] row;
    logic [STEP_W-1:0] col;
  } pos_t;

  // Apply one move to a (row, col) position; no saturation at the edges.
  function automatic pos_t step(input logic [STEP_W-1:0] row,
                                input logic [STEP_W-1:0] col,
                                input logic [1:0]        dir);
    pos_t nxt;
    nxt.row = row;
    nxt.col = col;
    case (dir)
      DIR_UP:    nxt.row = row - 16'd1;
      DIR_RIGHT: nxt.col = col + 16'd1;
      DIR_LEFT:  nxt.col = col - 16'd1;
      DIR_DOWN:  nxt.row = row + 16'd1;
      default: begin
        nxt.row = row;
        nxt.col = col;
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/path_replayer_buffer.sv
// Reversal buffer for drained moves: DEPTH x 2-bit storage with a
// synchronous write port and an asynchronous read port.
module path_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [1:0]    rdata
);

  logic [1:0] mem_r [DEPTH];

  // Capture one popped direction per cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/path_replayer.sv
// Drains the solver's direction stack (last move first) into a local
// buffer, then replays the moves first-to-last on a valid/ready port
// together with the grid coordinate each move lands on.
module path_replayer
  import path_replayer_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int CNT_W     = 9,
  parameter int COORD_W   = 4,
  parameter int START_ROW = 0,
  parameter int START_COL = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               stk_pop,
  input  logic [1:0]         stk_data,
  input  logic               stk_empty,
  output logic               move_valid,
  input  logic               move_ready,
  output logic [1:0]         move_dir,
  output logic [COORD_W-1:0] move_row,
  output logic [COORD_W-1:0] move_col,
  output logic [CNT_W-1:0]   path_len,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int                 AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0]     DEPTH_C = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]   ZERO_C  = CNT_W'(0);
  localparam logic [CNT_W-1:0]   ONE_C   = CNT_W'(1);
  localparam logic [COORD_W-1:0] SROW_C  = COORD_W'(START_ROW);
  localparam logic [COORD_W-1:0] SCOL_C  = COORD_W'(START_COL);

  state_t             state_r;
  logic [CNT_W-1:0]   wr_r;
  logic [CNT_W-1:0]   rd_r;
  logic               pop_d_r;
  logic [COORD_W-1:0] cur_row_r;
  logic [COORD_W-1:0] cur_col_r;
  logic [CNT_W-1:0]   path_len_r;
  logic               overflow_r;

  // Entries captured so far plus the one whose data arrives this cycle.
  logic [CNT_W:0]     fill_s;
  logic [1:0]         rd_dir_s;
  pos_t               next_pos_s;
  logic               step_unused_s;

  assign fill_s = {1'b0, wr_r} + {{CNT_W{1'b0}}, pop_d_r};

  path_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    ((state_r == ST_DRAIN) && pop_d_r),
    .waddr (wr_r[AW-1:0]),
    .wdata (stk_data),
    .raddr (rd_r[AW-1:0]),
    .rdata (rd_dir_s)
  );

  assign next_pos_s    = step(STEP_W'(cur_row_r), STEP_W'(cur_col_r), rd_dir_s);
  assign step_unused_s = ^{next_pos_s.row[STEP_W-1:COORD_W], next_pos_s.col[STEP_W-1:COORD_W]};

  assign busy     = (state_r != ST_IDLE);
  assign done     = (state_r == ST_DONE);
  assign path_len = path_len_r;
  assign overflow = overflow_r;

  // Pop request and presented move, both decoded from the current state.
  always_comb begin
    stk_pop    = 1'b0;
    move_valid = 1'b0;
    move_dir   = 2'b00;
    move_row   = {COORD_W{1'b0}};
    move_col   = {COORD_W{1'b0}};
    if (state_r == ST_DRAIN) begin
      stk_pop = !stk_empty && (fill_s < DEPTH_C);
    end else begin
      stk_pop = 1'b0;
    end
    if ((state_r == ST_EMIT) && (wr_r != ZERO_C)) begin
      move_valid = 1'b1;
      move_dir   = rd_dir_s;
      move_row   = next_pos_s.row[COORD_W-1:0];
      move_col   = next_pos_s.col[COORD_W-1:0];
    end else begin
      move_valid = 1'b0;
    end
  end

  // Drain/replay sequencer and position tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wr_r       <= ZERO_C;
      rd_r       <= ZERO_C;
      pop_d_r    <= 1'b0;
      cur_row_r  <= SROW_C;
      cur_col_r  <= SCOL_C;
      path_len_r <= ZERO_C;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            wr_r       <= ZERO_C;
            pop_d_r    <= 1'b0;
            path_len_r <= ZERO_C;
            overflow_r <= 1'b0;
            cur_row_r  <= SROW_C;
            cur_col_r  <= SCOL_C;
            state_r    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          pop_d_r <= stk_pop;
          if (pop_d_r) begin
            wr_r <= fill_s[CNT_W-1:0];
          end
          // Buffer full with entries still stacked: keep what we have.
          if ((fill_s == DEPTH_C) && !stk_empty) begin
            overflow_r <= 1'b1;
            path_len_r <= fill_s[CNT_W-1:0];
            rd_r       <= fill_s[CNT_W-1:0] - ONE_C;
            state_r    <= ST_EMIT;
          end else if (stk_empty && !pop_d_r) begin
            path_len_r <= wr_r;
            rd_r       <= wr_r - ONE_C;
            state_r    <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (wr_r == ZERO_C) begin
            state_r <= ST_DONE;
          end else if (move_ready) begin
            cur_row_r <= move_row;
            cur_col_r <= move_col;
            if (rd_r == ZERO_C) begin
              state_r <= ST_DONE;
            end else begin
              rd_r <= rd_r - ONE_C;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_replayer.sv
// Directed bench for path_replayer: behavioural direction stacks feed a
// full-size instance and a DEPTH=4 instance; expected moves are queued
// when the stack is loaded and compared as each move is accepted.
module tb_path_replayer;

  logic       clk;
  logic       rst;
  // Full-size instance and its stack
  logic       start, stk_pop, stk_empty, move_valid, move_ready, busy, done, overflow;
  logic [1:0] stk_data, move_dir;
  logic [3:0] move_row, move_col;
  logic [8:0] path_len;
  logic       push;
  logic [1:0] push_data;
  logic [1:0] mem [32];
  logic [4:0] sp;
  // DEPTH=4 instance and its stack
  logic       start4, stk_pop4, stk_empty4, move_valid4, move_ready4, busy4, done4, overflow4;
  logic [1:0] stk_data4, move_dir4;
  logic [3:0] move_row4, move_col4;
  logic [2:0] path_len4;
  logic       push4;
  logic [1:0] push_data4;
  logic [1:0] mem4 [32];
  logic [4:0] sp4;

  int checks, errors;
  int pops, pops4, run, max_run, valids, moves, moves4, dones, dones4;
  logic [9:0] exp_q[$];
  logic [9:0] exp4_q[$];

  path_replayer dut (
    .clk(clk), .rst(rst), .start(start), .stk_pop(stk_pop), .stk_data(stk_data),
    .stk_empty(stk_empty), .move_valid(move_valid), .move_ready(move_ready),
    .move_dir(move_dir), .move_row(move_row), .move_col(move_col),
    .path_len(path_len), .busy(busy), .done(done), .overflow(overflow)
  );

  path_replayer #(.DEPTH(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .stk_pop(stk_pop4), .stk_data(stk_data4),
    .stk_empty(stk_empty4), .move_valid(move_valid4), .move_ready(move_ready4),
    .move_dir(move_dir4), .move_row(move_row4), .move_col(move_col4),
    .path_len(path_len4), .busy(busy4), .done(done4), .overflow(overflow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stacks: data_out registered on an accepted pop.
  always @(posedge clk) begin
    if (push) begin
      mem[sp] <= push_data;
      sp      <= sp + 5'd1;
    end else if (stk_pop && sp != 5'd0) begin
      stk_data <= mem[sp - 5'd1];
      sp       <= sp - 5'd1;
    end
    if (push4) begin
      mem4[sp4] <= push_data4;
      sp4       <= sp4 + 5'd1;
    end else if (stk_pop4 && sp4 != 5'd0) begin
      stk_data4 <= mem4[sp4 - 5'd1];
      sp4       <= sp4 - 5'd1;
    end
  end

  assign stk_empty  = (sp == 5'd0);
  assign stk_empty4 = (sp4 == 5'd0);

  initial begin
    sp = 5'd0; sp4 = 5'd0; stk_data = 2'b00; stk_data4 = 2'b00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample outputs 1 time unit after the negedge where inputs were set,
  // then advance to the next negedge.
  task automatic tick();
    logic [9:0] e;
    #1;
    if (stk_pop) begin
      pops++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (stk_pop4) pops4++;
    if (move_valid) valids++;
    if (move_valid && move_ready) begin
      moves++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("move", 32'({move_dir, move_row, move_col}), 32'(e));
      end
    end
    if (move_valid4 && move_ready4) begin
      moves4++;
      check("sb4_nonempty", 32'(exp4_q.size() != 0), 32'd1);
      if (exp4_q.size() != 0) begin
        e = exp4_q.pop_front();
        check("move4", 32'({move_dir4, move_row4, move_col4}), 32'(e));
      end
    end
    if (done) dones++;
    if (done4) dones4++;
    @(negedge clk);
  endtask

  task automatic clr();
    pops = 0; pops4 = 0; run = 0; max_run = 0; valids = 0;
    moves = 0; moves4 = 0; dones = 0; dones4 = 0;
  endtask

  task automatic push_stk(input logic sel, input logic [1:0] d);
    if (sel) begin push4 = 1'b1; push_data4 = d; end
    else begin push = 1'b1; push_data = d; end
    tick();
    push = 1'b0; push4 = 1'b0;
  endtask

  task automatic pulse_start(input logic sel);
    if (sel) start4 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0; start4 = 1'b0;
  endtask

  // Run until done is seen (bounded), then two more cycles so a stretched
  // done pulse would be counted.
  task automatic run_done(input logic sel, input int budget);
    int n;
    n = 0;
    while (((sel ? dones4 : dones) == 0) && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 32'((sel ? dones4 : dones) != 0), 32'd1);
    tick();
    tick();
    check("done_once", 32'(sel ? dones4 : dones), 32'd1);
  endtask

  initial begin
    int n;
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; start4 = 1'b0; move_ready = 1'b1; move_ready4 = 1'b1;
    push = 1'b0; push4 = 1'b0; push_data = 2'b00; push_data4 = 2'b00;
    clr();
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", 32'({stk_pop, move_valid, done, overflow}), 32'd0);
    check("rst_move", 32'({move_dir, move_row, move_col}), 32'd0);
    check("rst_path_len", 32'(path_len), 32'd0);
    check("rst_busy4", 32'({busy4, done4, overflow4}), 32'd0);

    // Three-move path; stack pushed 01,01,11
    push_stk(1'b0, 2'b01); push_stk(1'b0, 2'b01); push_stk(1'b0, 2'b11);
    exp_q.push_back({2'b01, 4'd0, 4'd1});
    exp_q.push_back({2'b01, 4'd0, 4'd2});
    exp_q.push_back({2'b11, 4'd1, 4'd2});
    clr();
    pulse_start(1'b0);
    run_done(1'b0, 60);
    check("t1_pops", 32'(pops), 32'd3);
    check("t1_pop_run", 32'(max_run), 32'd3);
    check("t1_moves", 32'(moves), 32'd3);
    check("t1_path_len", 32'(path_len), 32'd3);
    check("t1_sb_drained", 32'(exp_q.size()), 32'd0);
    check("t1_overflow", 32'(overflow), 32'd0);

    // Empty stack: DRAIN, EMIT, then DONE is visible at the third sample
    // after the start cycle (two clocks after start is registered).
    clr();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (dones == 0 && n < 20) begin
      tick();
      n++;
    end
    check("t2_done_latency", 32'(n), 32'd3);
    tick(); tick();
    check("t2_pops", 32'(pops), 32'd0);
    check("t2_valids", 32'(valids), 32'd0);
    check("t2_path_len", 32'(path_len), 32'd0);
    check("t2_done_once", 32'(dones), 32'd1);

    // Back-pressure: path 01,11 with ready low for 5 cycles
    push_stk(1'b0, 2'b01); push_stk(1'b0, 2'b11);
    exp_q.push_back({2'b01, 4'd0, 4'd1});
    exp_q.push_back({2'b11, 4'd1, 4'd1});
    move_ready = 1'b0;
    clr();
    pulse_start(1'b0);
    n = 0;
    while (valids == 0 && n < 30) begin
      tick();
      n++;
    end
    check("t3_valid_seen", 32'(valids != 0), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold", 32'({move_valid, move_dir, move_row, move_col}), 32'({1'b1, 2'b01, 4'd0, 4'd1}));
      tick();
    end
    check("t3_no_accept", 32'(moves), 32'd0);
    move_ready = 1'b1;
    run_done(1'b0, 30);
    check("t3_moves", 32'(moves), 32'd2);
    check("t3_sb_drained", 32'(exp_q.size()), 32'd0);

    // DEPTH=4 instance with 5 stacked entries: bottom one is left behind
    push_stk(1'b1, 2'b01); push_stk(1'b1, 2'b01); push_stk(1'b1, 2'b11);
    push_stk(1'b1, 2'b11); push_stk(1'b1, 2'b10);
    exp4_q.push_back({2'b01, 4'd0, 4'd1});
    exp4_q.push_back({2'b11, 4'd1, 4'd1});
    exp4_q.push_back({2'b11, 4'd2, 4'd1});
    exp4_q.push_back({2'b10, 4'd2, 4'd0});
    clr();
    pulse_start(1'b1);
    run_done(1'b1, 60);
    check("t4_pops", 32'(pops4), 32'd4);
    check("t4_overflow", 32'(overflow4), 32'd1);
    check("t4_stack_left", 32'(stk_empty4), 32'd0);
    check("t4_path_len", 32'(path_len4), 32'd4);
    check("t4_moves", 32'(moves4), 32'd4);
    check("t4_sb_drained", 32'(exp4_q.size()), 32'd0);

    // Reset during a 6-entry drain after two pops
    push_stk(1'b0, 2'b01); push_stk(1'b0, 2'b01); push_stk(1'b0, 2'b11);
    push_stk(1'b0, 2'b10); push_stk(1'b0, 2'b00); push_stk(1'b0, 2'b00);
    clr();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_pops_before_rst", 32'(pops), 32'd2);
    check("t5_after_rst", 32'({busy, stk_pop, move_valid}), 32'd0);
    exp_q.push_back({2'b01, 4'd0, 4'd1});
    exp_q.push_back({2'b01, 4'd0, 4'd2});
    exp_q.push_back({2'b11, 4'd1, 4'd2});
    exp_q.push_back({2'b10, 4'd1, 4'd1});
    clr();
    pulse_start(1'b0);
    run_done(1'b0, 60);
    check("t5_pops", 32'(pops), 32'd4);
    check("t5_moves", 32'(moves), 32'd4);
    check("t5_path_len", 32'(path_len), 32'd4);
    check("t5_stack_empty", 32'(stk_empty), 32'd1);

    // Single up move from (0,0) wraps the row
    push_stk(1'b0, 2'b00);
    exp_q.push_back({2'b00, 4'd15, 4'd0});
    clr();
    pulse_start(1'b0);
    run_done(1'b0, 30);
    check("t6_moves", 32'(moves), 32'd1);
    check("t6_path_len", 32'(path_len), 32'd1);
    check("t6_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
